// File: rtl/fetch_stage.sv
// Instruction fetch front end: drives a 1-cycle-latency instruction memory,
// buffers returned words so decode stalls lose nothing, and honours
// flush/redirect from execute and halt from retire.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        bubble_out,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e            state_r;
  state_e            state_next_s;

  logic [15:0]       fetch_pc_r;
  logic              inflight_valid_r;
  logic [15:0]       inflight_pc_r;

  logic [15:0]       q_instr_r [FIFO_DEPTH];
  logic [15:0]       q_pc_r    [FIFO_DEPTH];
  logic [PTR_W-1:0]  q_head_r;
  logic [PTR_W-1:0]  q_tail_r;
  logic [CNT_W-1:0]  q_count_r;

  logic              q_empty_s;
  logic              bubble_s;
  logic              deq_s;
  logic [OCC_W-1:0]  occ_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              normal_s;

  // Circular pointer advance, wrapping at the last queue slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // State register: RUN after reset, HALTED is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: halt retires the front end permanently.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_RUN;
    endcase
  end

  // Output logic: choose the presented word (queue head, then bypass of the
  // returning memory word) and decide whether a new read may be issued.
  always_comb begin
    q_empty_s = (q_count_r == {CNT_W{1'b0}});
    bubble_s  = 1'b1;
    instr_out = 16'h0000;
    pc_out    = 16'h0000;
    if (!rst_n || (state_r == ST_HALTED)) begin
      bubble_s = 1'b1;
    end else if (!q_empty_s) begin
      bubble_s  = 1'b0;
      instr_out = q_instr_r[q_head_r];
      pc_out    = q_pc_r[q_head_r];
    end else if (inflight_valid_r) begin
      bubble_s  = 1'b0;
      instr_out = mem_rdata;
      pc_out    = inflight_pc_r;
    end else begin
      bubble_s = 1'b1;
    end

    deq_s = !bubble_s && !stall;
    // Words outstanding after this cycle's dequeue; deq implies something is present.
    occ_s = OCC_W'(q_count_r) + OCC_W'(inflight_valid_r) - OCC_W'(deq_s);
    normal_s = rst_n && (state_r == ST_RUN) && !halt && !flush;
    issue_s  = normal_s && (occ_s < OCC_W'(FIFO_DEPTH));

    // The returning word goes to the queue unless decode took it via bypass.
    push_s = inflight_valid_r && !(q_empty_s && deq_s);
    pop_s  = deq_s && !q_empty_s;

    bubble_out = bubble_s;
    mem_en     = issue_s;
    mem_addr   = fetch_pc_r;
    halted     = rst_n && (state_r == ST_HALTED);
  end

  // Fetch PC, in-flight tracking and queue pointers; halt beats flush beats normal flow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_r       <= RESET_PC;
      inflight_valid_r <= 1'b0;
      inflight_pc_r    <= 16'h0000;
      q_head_r         <= {PTR_W{1'b0}};
      q_tail_r         <= {PTR_W{1'b0}};
      q_count_r        <= {CNT_W{1'b0}};
    end else if (state_r == ST_HALTED) begin
      inflight_valid_r <= 1'b0;
    end else if (halt || flush) begin
      inflight_valid_r <= 1'b0;
      q_head_r         <= {PTR_W{1'b0}};
      q_tail_r         <= {PTR_W{1'b0}};
      q_count_r        <= {CNT_W{1'b0}};
      if (!halt) begin
        fetch_pc_r <= redirect_pc;
      end
    end else begin
      inflight_valid_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + 16'h0001;
      end
      if (push_s) begin
        q_tail_r <= ptr_inc(q_tail_r);
      end
      if (pop_s) begin
        q_head_r <= ptr_inc(q_head_r);
      end
      case ({push_s, pop_s})
        2'b10:   q_count_r <= q_count_r + CNT_W'(1);
        2'b01:   q_count_r <= q_count_r - CNT_W'(1);
        default: q_count_r <= q_count_r;
      endcase
    end
  end

  // Queue storage: capture the returning word at the tail during normal flow.
  always_ff @(posedge clk) begin
    if (normal_s && push_s) begin
      q_instr_r[q_tail_r] <= mem_rdata;
      q_pc_r[q_tail_r]    <= inflight_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stall/flush traffic against a stream-level reference model.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        rst_n       = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata   = 16'h0000;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        bubble_out;
  logic        stall       = 1'b0;
  logic        flush       = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt        = 1'b0;
  logic        halted;

  // Wrap-around instance signals
  logic        rst_w_n      = 1'b0;
  logic [15:0] mem_addr_w;
  logic        mem_en_w;
  logic [15:0] mem_rdata_w  = 16'h0000;
  logic [15:0] instr_out_w;
  logic [15:0] pc_out_w;
  logic        bubble_out_w;
  logic        stall_w      = 1'b0;
  logic        flush_w      = 1'b0;
  logic [15:0] redirect_w   = 16'h0000;
  logic        halt_w       = 1'b0;
  logic        halted_w;

  fetch_stage #(.RESET_PC(16'h0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .instr_out(instr_out), .pc_out(pc_out),
    .bubble_out(bubble_out), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_w_n), .mem_addr(mem_addr_w), .mem_en(mem_en_w),
    .mem_rdata(mem_rdata_w), .instr_out(instr_out_w), .pc_out(pc_out_w),
    .bubble_out(bubble_out_w), .stall(stall_w), .flush(flush_w),
    .redirect_pc(redirect_w), .halt(halt_w), .halted(halted_w)
  );

  function automatic logic [15:0] mword(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // Synchronous instruction memories, one cycle latency
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mword(mem_addr);
    if (mem_en_w) mem_rdata_w <= mword(mem_addr_w);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: next PC decode should see, next PC to be read,
  // words issued but not yet consumed, and halt state.
  logic [15:0] exp_pc   = 16'h0000;
  logic [15:0] iss_pc   = 16'h0000;
  int          out_cnt  = 0;
  bit          halted_m = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit fl,
                      input logic [15:0] rpc, input bit hl);
    int deq;
    bit exp_bubble;
    bit exp_issue;
    @(negedge clk);
    rst_n = !rst; stall = st; flush = fl; redirect_pc = rpc; halt = hl;
    #1;
    if (rst) begin
      chk("rst_mem_en", mem_en, 16'd0);
      chk("rst_bubble", bubble_out, 16'd1);
      chk("rst_instr", instr_out, 16'h0000);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_halted", halted, 16'd0);
      exp_pc = 16'h0000; iss_pc = 16'h0000; out_cnt = 0; halted_m = 1'b0;
    end else if (halted_m) begin
      chk("halt_halted", halted, 16'd1);
      chk("halt_bubble", bubble_out, 16'd1);
      chk("halt_mem_en", mem_en, 16'd0);
      chk("halt_instr", instr_out, 16'h0000);
      chk("halt_pc", pc_out, 16'h0000);
    end else begin
      exp_bubble = (out_cnt == 0);
      deq        = (!exp_bubble && !st) ? 1 : 0;
      exp_issue  = !hl && !fl && ((out_cnt - deq) < 2);
      chk("halted", halted, 16'd0);
      chk("bubble", bubble_out, 16'(exp_bubble));
      if (exp_bubble) begin
        chk("bub_instr", instr_out, 16'h0000);
        chk("bub_pc", pc_out, 16'h0000);
      end else begin
        chk("pc", pc_out, exp_pc);
        chk("instr", instr_out, mword(exp_pc));
      end
      chk("mem_en", mem_en, 16'(exp_issue));
      if (exp_issue) chk("mem_addr", mem_addr, iss_pc);
      if (hl) begin
        halted_m = 1'b1;
      end else if (fl) begin
        exp_pc = rpc; iss_pc = rpc; out_cnt = 0;
      end else begin
        if (deq != 0) exp_pc = exp_pc + 16'h0001;
        if (exp_issue) iss_pc = iss_pc + 16'h0001;
        out_cnt = out_cnt + (exp_issue ? 1 : 0) - deq;
      end
    end
  endtask

  task automatic rand_steps(input int n, input int stall_pct, input int flush_pct, input bit with_halt);
    bit st, fl, hl;
    logic [15:0] rpc;
    for (int i = 0; i < n; i++) begin
      st  = ($urandom_range(0, 99) < stall_pct);
      fl  = ($urandom_range(0, 99) < flush_pct);
      hl  = with_halt && ($urandom_range(0, 9) == 0);
      rpc = 16'($urandom_range(0, 65535));
      step(1'b0, st, fl, rpc, hl);
    end
  endtask

  logic [15:0] wrap_pcs [4];

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Streaming: bubble then pcs 0,1,2
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // pc 3 stalled three cycles, then accepted
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Flush with stall while pc 5 presented, redirect to 0x0040
    step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Flush toward the top of the address space to cross FFFF->0000
    step(1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    // Random stall/flush traffic
    rand_steps(300, 40, 5, 1'b0);
    // Fill queue with stalls, then reset mid-stall
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    rand_steps(20, 30, 0, 1'b0);
    // Halt together with flush, then ignored activity for 50 cycles
    step(1'b0, 1'b0, 1'b1, 16'h0123, 1'b1);
    rand_steps(50, 50, 30, 1'b1);
    // Recover through reset
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    rand_steps(30, 30, 5, 1'b0);

    // Wrap-around instance: RESET_PC = FFFE
    wrap_pcs[0] = 16'hFFFE; wrap_pcs[1] = 16'hFFFF;
    wrap_pcs[2] = 16'h0000; wrap_pcs[3] = 16'h0001;
    @(negedge clk);
    rst_w_n = 1'b1;
    #1;
    chk("wrap_bubble0", bubble_out_w, 16'd1);
    chk("wrap_mem_en0", mem_en_w, 16'd1);
    chk("wrap_addr0", mem_addr_w, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("wrap_bubble", bubble_out_w, 16'd0);
      chk("wrap_pc", pc_out_w, wrap_pcs[i]);
      chk("wrap_instr", instr_out_w, mword(wrap_pcs[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
